// File: rtl/mque_rd_sch.sv
// -----------------------------------------------------------------------------
// mque_rd_sch
//
// Round-robin read scheduler for a multi-queue FIFO that shares one RAM across
// PORT_NUM logical queues. Each cycle it picks one non-empty, enabled, unlocked
// queue and strobes a read to it. It then realigns the returned data with its
// source port and presents the result on a valid/ready stream through a small
// output buffer. Reads are only issued while the buffer has guaranteed room for
// every read already in flight. Because of this, downstream back-pressure can
// never cause an over-read.
//
// Ports
//   clks, reset_n         clock, synchronous active-low reset
//   sch_en                global issue enable
//   port_en[PORT_NUM]     per-port issue enable
//   ef[PORT_NUM]          queue empty flags (may lag a read by up to LOCK_CYC)
//   rd, rport             queue read strobe and port
//   rdata                 queue read data, valid RD_LAT cycles after rd
//   dout_vld/data/port    output stream (first-word-fall-through)
//   dout_rdy              downstream accept
//   busy                  reads in flight or output buffer non-empty
// -----------------------------------------------------------------------------
module mque_rd_sch #(
    parameter int PORT_NUM    = 2,
    parameter int PORT_WIDTH  = 1,
    parameter int RDATA_WIDTH = 72,
    parameter int RD_LAT      = 2,
    parameter int LOCK_CYC    = 2,
    parameter int OUT_DEPTH   = 4,
    parameter int OUT_AW      = 2
) (
    input  logic                   clks,
    input  logic                   reset_n,
    input  logic                   sch_en,
    input  logic [PORT_NUM-1:0]    port_en,
    input  logic [PORT_NUM-1:0]    ef,
    output logic                   rd,
    output logic [PORT_WIDTH-1:0]  rport,
    input  logic [RDATA_WIDTH-1:0] rdata,
    output logic                   dout_vld,
    output logic [RDATA_WIDTH-1:0] dout_data,
    output logic [PORT_WIDTH-1:0]  dout_port,
    input  logic                   dout_rdy,
    output logic                   busy
);

    localparam int LCW = (LOCK_CYC < 1) ? 1 : $clog2(LOCK_CYC + 1);

    // Control state (reset)
    logic [PORT_WIDTH-1:0] last_q, last_d;
    logic [LCW-1:0]        lock_q [PORT_NUM];
    logic [LCW-1:0]        lock_d [PORT_NUM];
    logic [RD_LAT-1:0]     pv_q, pv_d;
    logic [OUT_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_AW:0]       occ_q, occ_d;

    // Data state (not reset)
    logic [PORT_WIDTH-1:0]  pp_q [RD_LAT];
    logic [PORT_WIDTH-1:0]  pp_d [RD_LAT];
    logic [RDATA_WIDTH-1:0] data_mem [OUT_DEPTH];
    logic [PORT_WIDTH-1:0]  port_mem [OUT_DEPTH];

    logic [PORT_NUM-1:0]   elig;
    logic                  found;
    logic [PORT_WIDTH-1:0] grant;
    int                    inflight;
    logic                  credit_ok;
    logic                  push, pop;

    // Arbiter: first eligible port after `last`, wrapping modulo PORT_NUM.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        elig  = '0;
        found = 1'b0;
        grant = last_q;
        for (int i = 0; i < PORT_NUM; i++) begin
            elig[i] = port_en[i] & ~ef[i] & (lock_q[i] == '0);
        end
        for (int k = 1; k <= PORT_NUM; k++) begin
            int idx;
            idx = int'(last_q) + k;
            if (idx >= PORT_NUM) idx = idx - PORT_NUM;
            if (!found && elig[idx]) begin
                found = 1'b1;
                grant = PORT_WIDTH'(idx);
            end
        end
    end

    // Credit: every in-flight read already owns a buffer slot. Same-cycle pops
    // are deliberately not counted, which keeps this path off dout_rdy.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (pv_q[i]) inflight = inflight + 1;
        end
    end

    assign credit_ok = (int'(occ_q) + inflight) < OUT_DEPTH;
    assign rd        = reset_n & sch_en & credit_ok & found;
    assign rport     = rd ? grant : last_q;

    assign push      = pv_q[RD_LAT-1];
    assign dout_vld  = (occ_q != '0);
    assign pop       = dout_vld & dout_rdy;
    assign dout_data = data_mem[rd_ptr_q];
    // Masked so the port reads 0 while the (unreset) buffer is empty.
    assign dout_port = dout_vld ? port_mem[rd_ptr_q] : '0;
    assign busy      = (inflight != 0) | dout_vld;

    always_comb begin
        last_d = rd ? grant : last_q;

        // A granted port is locked long enough for its ef to catch up.
        for (int i = 0; i < PORT_NUM; i++) begin
            lock_d[i] = lock_q[i];
            if (rd && (grant == PORT_WIDTH'(i))) begin
                lock_d[i] = LCW'(LOCK_CYC);
            end else if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - LCW'(1);
            end
        end

        // Return pipeline: stage RD_LAT-1 lines up with rdata.
        pv_d[0] = rd;
        pp_d[0] = grant;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pp_d[i] = pp_q[i-1];
        end

        wr_ptr_d = push ? wr_ptr_q + OUT_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + OUT_AW'(1) : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop)      occ_d = occ_q + (OUT_AW+1)'(1);
        else if (!push && pop) occ_d = occ_q - (OUT_AW+1)'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clks) begin
        if (!reset_n) begin
            last_q   <= PORT_WIDTH'(PORT_NUM - 1);
            for (int i = 0; i < PORT_NUM; i++) lock_q[i] <= '0;
            pv_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            last_q   <= last_d;
            lock_q   <= lock_d;
            pv_q     <= pv_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // NOTE: the port pipeline and buffer storage are not reset. Their contents
    // are only observed behind valid bits and pointers that are reset, so
    // resetting them would only add reset fan-out and block RAM inference.
    always_ff @(posedge clks) begin
        pp_q <= pp_d;
        if (push) begin
            data_mem[wr_ptr_q] <= rdata;
            port_mem[wr_ptr_q] <= pp_q[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_mque_rd_sch.sv
module tb_mque_rd_sch;
  localparam int PN = 4;
  localparam int PW = 2;
  localparam int DW = 72;
  localparam int RL = 2;
  localparam int LC = 2;
  localparam int OD = 4;
  localparam int OA = 2;

  logic          clks = 1'b0;
  logic          reset_n;
  logic          sch_en;
  logic [PN-1:0] port_en;
  logic [PN-1:0] ef;
  logic          rd;
  logic [PW-1:0] rport;
  logic [DW-1:0] rdata;
  logic          dout_vld;
  logic [DW-1:0] dout_data;
  logic [PW-1:0] dout_port;
  logic          dout_rdy;
  logic          busy;

  always #5 clks = ~clks;

  mque_rd_sch #(
    .PORT_NUM(PN), .PORT_WIDTH(PW), .RDATA_WIDTH(DW), .RD_LAT(RL),
    .LOCK_CYC(LC), .OUT_DEPTH(OD), .OUT_AW(OA)
  ) dut (
    .clks(clks), .reset_n(reset_n), .sch_en(sch_en), .port_en(port_en),
    .ef(ef), .rd(rd), .rport(rport), .rdata(rdata),
    .dout_vld(dout_vld), .dout_data(dout_data), .dout_port(dout_port),
    .dout_rdy(dout_rdy), .busy(busy)
  );

  // Scoreboard entry: expected beat plus the cycle its read was issued.
  typedef struct {
    logic [PW-1:0] port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mq[PN][$];      // queue contents seen by the environment
  logic [DW-1:0] rq[RL+1];       // rdata delay line
  logic [PN-1:0] ef_lag;         // ef lags queue contents by two cycles

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;
  int bad_cnt = 0;

  // Reference arbiter state: last grant and issue cycle of each port.
  int m_last;
  int last_rd[PN];
  bit in_rst = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic fill(input int n);
    for (int p = 0; p < PN; p++)
      for (int j = 0; j < n; j++) mq[p].push_back(rnd_data());
  endtask

  task automatic model_reset();
    m_last = PN - 1;
    for (int p = 0; p < PN; p++) last_rd[p] = -100;
    sb.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, then evaluate the
  // reference model against the settled combinational outputs.
  task automatic cycle(input bit r, input bit se, input logic [PN-1:0] pe, input bit dr);
    bit exp_rd;
    int g;
    logic [DW-1:0] d;
    @(negedge clks);
    cyc++;
    reset_n  = r;
    sch_en   = se;
    port_en  = pe;
    dout_rdy = dr;
    ef = ef_lag;
    for (int p = 0; p < PN; p++) ef_lag[p] = (mq[p].size() == 0);
    for (int i = RL; i > 0; i--) rq[i] = rq[i-1];
    rq[0] = rnd_data();
    rdata = rq[RL];
    #1;
    if (!r) begin
      check("rst_rd", rd, 0);
      if (in_rst) begin
        check("rst_rport", rport, PN - 1);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_dout_port", dout_port, 0);
        check("rst_busy", busy, 0);
      end
      in_rst = 1;
      model_reset();
    end else begin
      in_rst = 0;
      exp_rd = 0;
      g = 0;
      if (se && sb.size() < OD) begin
        for (int k = 1; k <= PN; k++) begin
          int p;
          p = (m_last + k) % PN;
          if (!exp_rd && pe[p] && !ef[p] && (cyc - last_rd[p] > LC)) begin
            exp_rd = 1;
            g = p;
          end
        end
      end
      check("rd", rd, exp_rd);
      check("rport", rport, exp_rd ? g : m_last);
      check("busy", busy, sb.size() != 0);
      if (exp_rd) begin
        d = (mq[g].size() != 0) ? mq[g][0] : '0;
        sb.push_back('{PW'(g), d, cyc});
        m_last = g;
        last_rd[g] = cyc;
      end
      if (rd) begin
        rd_cnt++;
        if (rport == 0 || rport == 2) bad_cnt++;
        check("no_underflow", mq[rport].size() != 0, 1);
        if (mq[rport].size() != 0) rq[0] = mq[rport].pop_front();
      end
    end
  endtask

  task automatic drain(input logic [PN-1:0] pe);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      cycle(1, 0, pe, 1);
      n++;
    end
    check("drain_done", (sb.size() == 0) && !busy, 1);
  endtask

  // Monitor: checks dout_vld timing, pops and compares accepted beats, and
  // checks the head stays stable while stalled.
  logic [DW-1:0] h_data;
  logic [PW-1:0] h_port;
  bit            h_v = 0;

  always begin
    bit   exp_vld;
    exp_t e;
    @(negedge clks);
    #2;
    if (!reset_n) begin
      h_v = 0;
    end else begin
      exp_vld = (sb.size() != 0) && (sb[0].cyc + RL + 1 <= cyc);
      check("dout_vld", dout_vld, exp_vld);
      if (h_v && dout_vld) begin
        check("hold_data", dout_data, h_data);
        check("hold_port", dout_port, h_port);
      end
      if (dout_vld && dout_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("dout_data", dout_data, e.data);
          check("dout_port", dout_port, e.port);
        end
        h_v = 0;
      end else if (dout_vld) begin
        h_v = 1;
        h_data = dout_data;
        h_port = dout_port;
      end else begin
        h_v = 0;
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    reset_n  = 0;
    sch_en   = 0;
    port_en  = '0;
    dout_rdy = 0;
    rdata    = '0;
    for (int i = 0; i <= RL; i++) rq[i] = '0;
    model_reset();
    fill(20);
    ef     = '0;
    ef_lag = '0;

    // Reset held with queues non-empty, then round robin at full rate.
    repeat (3) cycle(0, 1, '1, 1);
    rd_cnt = 0;
    repeat (30) cycle(1, 1, '1, 1);
    check("rr_full_rate", rd_cnt, 30);

    // Lockout: a lone port with five entries.
    drain('1);
    for (int p = 0; p < PN; p++) mq[p].delete();
    repeat (5) mq[1].push_back(rnd_data());
    repeat (3) cycle(1, 0, '1, 1);
    rd_cnt = 0;
    repeat (25) cycle(1, 1, '1, 1);
    check("lock_reads", rd_cnt, 5);

    // Back-pressure: no more reads than buffer entries, then full drain.
    drain('1);
    fill(10);
    repeat (3) cycle(1, 0, '1, 0);
    rd_cnt = 0;
    repeat (10) cycle(1, 1, '1, 0);
    check("bp_reads", rd_cnt, OD);
    repeat (20) cycle(1, 1, '1, 1);

    // Masking, then sch_en cleared mid-stream.
    drain('1);
    fill(8);
    repeat (3) cycle(1, 0, 4'b1010, 1);
    rd_cnt = 0;
    bad_cnt = 0;
    repeat (20) cycle(1, 1, 4'b1010, 1);
    check("mask_reads", rd_cnt > 0, 1);
    check("mask_bad_port", bad_cnt, 0);
    drain(4'b1010);

    // Reset with reads in flight: those beats must never appear.
    fill(4);
    repeat (2) cycle(1, 0, '1, 1);
    repeat (5) cycle(1, 1, '1, 1);
    cycle(0, 0, '1, 1);
    repeat (6) cycle(1, 0, '1, 1);
    check("post_reset_busy", busy, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 0) mq[$urandom_range(0, PN - 1)].push_back(rnd_data());
      cycle(1, $urandom_range(0, 9) != 0, PN'($urandom()), $urandom_range(0, 3) != 0);
    end
    drain('1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
